// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants and types for the VGA timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_gen_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    // Raw (polarity-free) raster state carried down the latency line.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } raster_t;

    function automatic int span_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-fetch handshake between the timing generator and the pixel pipeline.
interface vga_timing_gen_if #(
    parameter int COLOR_W = 6
);
    import vga_timing_gen_pkg::*;

    logic               req;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               frame_start;
    logic [COLOR_W-1:0] pix_in;

    modport master (output req, output x, output y, output frame_start, input pix_in);
    modport slave  (input req, input x, input y, input frame_start, output pix_in);

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Clock-enabled shift register with async active-low clear to INIT.
// DEPTH=0 degenerates to a combinational pass-through.
module sync_delay_line #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] sr_p [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) sr_p[i] <= INIT;
                end else if (ce) begin
                    sr_p[0] <= d;
                    for (int i = 1; i < DEPTH; i++) sr_p[i] <= sr_p[i-1];
                end
            end

            assign q = sr_p[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: issues pixel requests and drives sync/blank/colour
// to the DAC, delayed so pins line up with pixels returned LAT ticks after req.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int COLOR_W = 6,
    parameter int CLK_DIV = 4,
    parameter int H_ACT   = DEF_H_ACT,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int LAT     = 2
) (
    input  logic               xclk,
    input  logic               rst,
    vga_timing_gen_if.master   pix,
    output logic               de,
    output logic [COLOR_W-1:0] xrgb,
    output logic               xhs,
    output logic               xvs
);

    localparam int H_TOT = span_total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = span_total(V_ACT, V_FP, V_SYNC, V_BP);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (H_TOT > 1024 || V_TOT > 1024 || LAT < 0 || LAT > 15 || CLK_DIV < 1) begin : g_bad_params
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    logic [DIV_W-1:0]   div;
    logic               tick;
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] v;
    raster_t            raw;
    raster_t            raw_p0;
    raster_t            raw_d;
    logic [COORD_W-1:0] x_p0;
    logic [COORD_W-1:0] y_p0;
    logic               fs_p0;

    assign tick = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge xclk or negedge rst) begin
        if (!rst) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (h == COORD_W'(H_TOT - 1)) begin
                    h <= '0;
                    v <= (v == COORD_W'(V_TOT - 1)) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    always_comb begin
        raw        = '0;
        raw.active = (int'(h) < H_ACT) && (int'(v) < V_ACT);
        raw.hs     = (int'(h) >= H_ACT + H_FP) && (int'(h) < H_ACT + H_FP + H_SYNC);
        raw.vs     = (int'(v) >= V_ACT + V_FP) && (int'(v) < V_ACT + V_FP + V_SYNC);
    end

    // Stage p0: request register; coordinates hold their last active value.
    always_ff @(posedge xclk or negedge rst) begin
        if (!rst) begin
            raw_p0 <= '0;
            x_p0   <= '0;
            y_p0   <= '0;
            fs_p0  <= 1'b0;
        end else begin
            fs_p0 <= tick && (h == '0) && (v == '0);
            if (tick) begin
                raw_p0 <= raw;
                if (raw.active) begin
                    x_p0 <= h;
                    y_p0 <= v;
                end
            end
        end
    end

    assign pix.req         = raw_p0.active;
    assign pix.x           = x_p0;
    assign pix.y           = y_p0;
    assign pix.frame_start = fs_p0;

    // Latency compensation: raster state waits LAT ticks for the pixel to come back.
    sync_delay_line #(
        .WIDTH ($bits(raster_t)),
        .DEPTH (LAT),
        .INIT  ('0)
    ) u_dly (
        .clk   (xclk),
        .rst_n (rst),
        .ce    (tick),
        .d     (raw_p0),
        .q     (raw_d)
    );

    // Final stage: pin register, polarity applied here so the line holds raw state.
    always_ff @(posedge xclk or negedge rst) begin
        if (!rst) begin
            de   <= 1'b0;
            xrgb <= '0;
            xhs  <= ~HS_POL;
            xvs  <= ~VS_POL;
        end else if (tick) begin
            de   <= raw_d.active;
            xrgb <= raw_d.active ? pix.pix_in : '0;
            xhs  <= raw_d.hs ~^ HS_POL;
            xvs  <= raw_d.vs ~^ VS_POL;
        end
    end

endmodule
